// File: rtl/bus_xfer_sequencer_if.sv
// Command/strobe bundle between the transfer-command producer and bus_xfer_sequencer.
interface bus_xfer_if #(
   parameter int unsigned NSRC = 25
);
   logic            xfer_valid;
   logic            xfer_ready;
   logic [4:0]      xfer_src;
   logic [NSRC-1:0] xfer_dst;
   logic [NSRC-1:0] out_en;
   logic [NSRC-1:0] in_en;
   logic            busy;
   logic            done;
   logic            err;

   modport master (
      output xfer_valid, xfer_src, xfer_dst,
      input  xfer_ready, out_en, in_en, busy, done, err
   );

   modport slave (
      input  xfer_valid, xfer_src, xfer_dst,
      output xfer_ready, out_en, in_en, busy, done, err
   );
endinterface

// File: rtl/bus_xfer_sequencer.sv
// Queues {src, dst} bus-transfer commands and sequences each as a DRIVE/LATCH pair of one-hot strobes.
// Optional XFER_SELF_CHECK_EN: commands whose dst includes their own src are rejected.
module bus_xfer_sequencer #(
   parameter int unsigned NSRC  = 25,
   parameter int unsigned DEPTH = 2
) (
   input logic       clk,
   input logic       clr,
   bus_xfer_if.slave bus
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

`ifdef XFER_SELF_CHECK_EN
   localparam bit SELF_CHECK = 1'b1;
`else
   localparam bit SELF_CHECK = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, LATCH = 2'd2} state_t;

   state_t          state, state_nx;
   logic [4:0]      cur_src, src_nx;
   logic [NSRC-1:0] cur_dst, dst_nx;
   logic [4:0]      fifo_src [DEPTH];
   logic [NSRC-1:0] fifo_dst [DEPTH];
   logic [AW-1:0]   rd_ptr, wr_ptr;
   logic [CW-1:0]   count, count_nx;
   logic            accept, push, pop, bypass, take, fifo_nonempty;
   logic [4:0]      take_src;
   logic [NSRC-1:0] take_dst;
   logic            done_nx, err_nx, busy_nx;
   logic [NSRC-1:0] out_en_nx, in_en_nx;

   function automatic logic [NSRC-1:0] onehot(input logic [4:0] s);
      logic [NSRC-1:0] v;
      v = '0;
      for (int unsigned i = 0; i < NSRC; i++)
         if (32'(s) == i) v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic cmd_ok(input logic [4:0] s, input logic [NSRC-1:0] d);
      logic ok;
      ok = (32'(s) < NSRC) && (d != '0);
      if (SELF_CHECK && ((onehot(s) & d) != '0)) ok = 1'b0;
      return ok;
   endfunction

   assign fifo_nonempty  = (count != '0);
   assign bus.xfer_ready = (count != CW'(DEPTH));
   assign accept         = bus.xfer_valid & bus.xfer_ready;

   always_comb begin
      state_nx = state;
      src_nx   = cur_src;
      dst_nx   = cur_dst;
      pop      = 1'b0;
      bypass   = 1'b0;
      take     = 1'b0;
      take_src = fifo_src[rd_ptr];
      take_dst = fifo_dst[rd_ptr];
      done_nx  = 1'b0;
      err_nx   = 1'b0;

      unique case (state)
         IDLE: begin
            // An empty FIFO in IDLE hands the incoming command straight to the FSM,
            // so a transfer starts driving the cycle after it is accepted.
            if (fifo_nonempty) begin
               take = 1'b1;
               pop  = 1'b1;
            end else if (accept) begin
               take     = 1'b1;
               bypass   = 1'b1;
               take_src = bus.xfer_src;
               take_dst = bus.xfer_dst;
            end
         end
         DRIVE: state_nx = LATCH;
         LATCH: begin
            done_nx  = 1'b1;
            state_nx = IDLE;
            if (fifo_nonempty) begin
               take = 1'b1;
               pop  = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase

      if (take) begin
         if (cmd_ok(take_src, take_dst)) begin
            state_nx = DRIVE;
            src_nx   = take_src;
            dst_nx   = take_dst;
         end else begin
            err_nx   = 1'b1;
            state_nx = IDLE;
         end
      end

      push      = accept & ~bypass;
      count_nx  = count + CW'(push) - CW'(pop);
      out_en_nx = (state_nx != IDLE) ? onehot(src_nx) : '0;
      in_en_nx  = (state_nx == LATCH) ? dst_nx : '0;
      busy_nx   = (state_nx != IDLE) || (count_nx != '0);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state      <= IDLE;
         cur_src    <= '0;
         cur_dst    <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         bus.out_en <= '0;
         bus.in_en  <= '0;
         bus.done   <= 1'b0;
         bus.err    <= 1'b0;
         bus.busy   <= 1'b0;
      end else begin
         state      <= state_nx;
         cur_src    <= src_nx;
         cur_dst    <= dst_nx;
         count      <= count_nx;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         bus.out_en <= out_en_nx;
         bus.in_en  <= in_en_nx;
         bus.done   <= done_nx;
         bus.err    <= err_nx;
         bus.busy   <= busy_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clr) begin
         fifo_src[wr_ptr] <= bus.xfer_src;
         fifo_dst[wr_ptr] <= bus.xfer_dst;
      end
   end
endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Directed-vector bench for bus_xfer_sequencer: per-cycle strobe tables plus a done/err scoreboard.
module tb_bus_xfer_sequencer;
   localparam int unsigned NSRC = 25;
   localparam int unsigned NCYC = 12;

   logic clk = 1'b0;
   logic clr = 1'b1;
   always #5 clk = ~clk;

   bus_xfer_if #(.NSRC(NSRC)) bus ();

   bus_xfer_sequencer #(.NSRC(NSRC), .DEPTH(2)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus.slave)
   );

   typedef struct {
      logic        is_err;
      logic [24:0] oe;
      logic [24:0] ie;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   logic mon_on   = 1'b0;

   logic [31:0] t_oe [NCYC];
   logic [31:0] t_ie [NCYC];
   logic        t_done [NCYC];
   logic        t_err  [NCYC];
   logic        t_rdy  [NCYC];
   logic        t_busy [NCYC];
   logic        t_clr  [NCYC];
   logic [4:0]  cq_src[$];
   logic [24:0] cq_dst[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [4:0] s, input logic [24:0] d);
      exp_t e;
      logic self_hit;
      self_hit = 1'b0;
`ifdef XFER_SELF_CHECK_EN
      if (s < 5'd25) self_hit = ((d >> s) & 25'd1) != 25'd0;
`endif
      e.is_err = (s >= 5'd25) || (d == 25'd0) || self_hit;
      e.oe     = e.is_err ? 25'd0 : (25'd1 << s);
      e.ie     = e.is_err ? 25'd0 : d;
      return e;
   endfunction

   // Monitor: each done/err pulse retires the oldest expected command.
   initial begin
      logic [24:0] drv_oe, lat_oe, lat_ie;
      exp_t e;
      logic ev_err;
      drv_oe = '0; lat_oe = '0; lat_ie = '0;
      forever begin
         @(negedge clk);
         if (mon_on) begin
            chk("oe_onehot0", 32'($onehot0(bus.out_en)), 32'd1);
            if (bus.done) begin
               ev_err = 1'b0;
               if (sb.size() == 0) chk("sb_unexpected_done", 32'd1, 32'd0);
               else begin
                  e = sb.pop_front();
                  chk("sb_kind_done", 32'(ev_err), 32'(e.is_err));
                  chk("sb_drive_oe", 32'(drv_oe), 32'(e.oe));
                  chk("sb_latch_oe", 32'(lat_oe), 32'(e.oe));
                  chk("sb_latch_ie", 32'(lat_ie), 32'(e.ie));
               end
            end
            if (bus.err) begin
               ev_err = 1'b1;
               if (sb.size() == 0) chk("sb_unexpected_err", 32'd1, 32'd0);
               else begin
                  e = sb.pop_front();
                  chk("sb_kind_err", 32'(ev_err), 32'(e.is_err));
               end
            end
            if (bus.in_en != '0) begin
               lat_oe = bus.out_en;
               lat_ie = bus.in_en;
            end else if (bus.out_en != '0) begin
               drv_oe = bus.out_en;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_tables();
      for (int i = 0; i < int'(NCYC); i++) begin
         t_oe[i] = '0; t_ie[i] = '0; t_done[i] = 1'b0; t_err[i] = 1'b0;
         t_rdy[i] = 1'b1; t_busy[i] = 1'b0; t_clr[i] = 1'b0;
      end
      cq_src.delete();
      cq_dst.delete();
   endtask

   task automatic add_cmd(input logic [4:0] s, input logic [24:0] d);
      cq_src.push_back(s);
      cq_dst.push_back(d);
   endtask

   // Cycle c: inputs applied just after edge E(c-1), checked at mid-cycle, accepted at E(c).
   task automatic run_test(input string tag);
      int   ptr;
      logic rdy;
      ptr = 0;
      for (int c = 0; c < int'(NCYC); c++) begin
         clr = t_clr[c];
         if (ptr < cq_src.size()) begin
            bus.xfer_valid = 1'b1;
            bus.xfer_src   = cq_src[ptr];
            bus.xfer_dst   = cq_dst[ptr];
         end else begin
            bus.xfer_valid = 1'b0;
            bus.xfer_src   = '0;
            bus.xfer_dst   = '0;
         end
         @(negedge clk);
         rdy = bus.xfer_ready;
         chk($sformatf("%s c%0d out_en", tag, c), 32'(bus.out_en), t_oe[c]);
         chk($sformatf("%s c%0d in_en", tag, c), 32'(bus.in_en), t_ie[c]);
         chk($sformatf("%s c%0d done", tag, c), 32'(bus.done), 32'(t_done[c]));
         chk($sformatf("%s c%0d err", tag, c), 32'(bus.err), 32'(t_err[c]));
         chk($sformatf("%s c%0d ready", tag, c), 32'(rdy), 32'(t_rdy[c]));
         chk($sformatf("%s c%0d busy", tag, c), 32'(bus.busy), 32'(t_busy[c]));
         @(posedge clk);
         if (clr) begin
            sb.delete();
            if (bus.xfer_valid) ptr++;
         end else if (bus.xfer_valid && rdy) begin
            sb.push_back(model(bus.xfer_src, bus.xfer_dst));
            ptr++;
         end
         #1;
      end
      clr = 1'b0;
      bus.xfer_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.xfer_valid = 1'b0;
      bus.xfer_src   = '0;
      bus.xfer_dst   = '0;
      clr = 1'b1;
      tick();
      tick();
      @(negedge clk);
      chk("reset out_en", 32'(bus.out_en), 32'd0);
      chk("reset in_en", 32'(bus.in_en), 32'd0);
      chk("reset done", 32'(bus.done), 32'd0);
      chk("reset err", 32'(bus.err), 32'd0);
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset ready", 32'(bus.xfer_ready), 32'd1);
      tick();
      clr = 1'b0;
      mon_on = 1'b1;
      tick();

      // PC -> MAR
      clear_tables();
      add_cmd(5'd20, 25'h800000);
      t_oe[1] = 32'h100000; t_oe[2] = 32'h100000;
      t_ie[2] = 32'h800000;
      t_done[3] = 1'b1;
      t_busy[1] = 1'b1; t_busy[2] = 1'b1;
      run_test("single");

      // Four back-to-back commands; the FIFO fills once during the run
      clear_tables();
      add_cmd(5'd0, 25'h2); add_cmd(5'd1, 25'h4); add_cmd(5'd2, 25'h8); add_cmd(5'd3, 25'h10);
      t_oe[1] = 32'h1; t_oe[2] = 32'h1; t_oe[3] = 32'h2; t_oe[4] = 32'h2;
      t_oe[5] = 32'h4; t_oe[6] = 32'h4; t_oe[7] = 32'h8; t_oe[8] = 32'h8;
      t_ie[2] = 32'h2; t_ie[4] = 32'h4; t_ie[6] = 32'h8; t_ie[8] = 32'h10;
      t_done[3] = 1'b1; t_done[5] = 1'b1; t_done[7] = 1'b1; t_done[9] = 1'b1;
      t_rdy[4] = 1'b0;
      for (int i = 1; i <= 8; i++) t_busy[i] = 1'b1;
      run_test("b2b");

      // Out-of-range source from IDLE, then a normal command
      clear_tables();
      add_cmd(5'd27, 25'h1); add_cmd(5'd5, 25'h40);
      t_err[1] = 1'b1;
      t_oe[2] = 32'h20; t_oe[3] = 32'h20;
      t_ie[3] = 32'h40;
      t_done[4] = 1'b1;
      t_busy[2] = 1'b1; t_busy[3] = 1'b1;
      run_test("inv_idle");

      // Empty destination popped at the end of LATCH: done and err together
      clear_tables();
      add_cmd(5'd4, 25'h1); add_cmd(5'd6, 25'h0); add_cmd(5'd7, 25'h2);
      t_oe[1] = 32'h10; t_oe[2] = 32'h10; t_oe[4] = 32'h80; t_oe[5] = 32'h80;
      t_ie[2] = 32'h1; t_ie[5] = 32'h2;
      t_done[3] = 1'b1; t_done[6] = 1'b1;
      t_err[3] = 1'b1;
      for (int i = 1; i <= 5; i++) t_busy[i] = 1'b1;
      run_test("inv_latch");

      // clr during DRIVE with one command queued and another offered alongside clr
      clear_tables();
      add_cmd(5'd8, 25'h200); add_cmd(5'd9, 25'h400); add_cmd(5'd10, 25'h800); add_cmd(5'd11, 25'h1000);
      t_clr[3] = 1'b1;
      t_oe[1] = 32'h100; t_oe[2] = 32'h100; t_oe[3] = 32'h200;
      t_ie[2] = 32'h200;
      t_done[3] = 1'b1;
      t_busy[1] = 1'b1; t_busy[2] = 1'b1; t_busy[3] = 1'b1;
      run_test("clr_drive");

      // Self-load: R3 -> R3
      clear_tables();
      add_cmd(5'd3, 25'h8);
`ifdef XFER_SELF_CHECK_EN
      t_err[1] = 1'b1;
`else
      t_oe[1] = 32'h8; t_oe[2] = 32'h8;
      t_ie[2] = 32'h8;
      t_done[3] = 1'b1;
      t_busy[1] = 1'b1; t_busy[2] = 1'b1;
`endif
      run_test("self_load");

      tick();
      tick();
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
